// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundle of the requester-side and UART_Tx-side signals of uart_tx_arbiter.
//
//   Parameters : N_REQ (requesters), DWL (data word length)
//   Modports   : master - the arbiter (drives ack/grant/tx_* outputs)
//                slave  - the surroundings (requesters + UART_Tx instance)
//   Signals    : req, req_data, ack, grant_id, arb_busy  (requester side)
//                tx_en, tx_we, tx_data, tx_busy         (UART_Tx side)
//                dbg_state                              (arbiter FSM state)
//                err  (only when UART_ARB_TIMEOUT_EN is defined)
//
// Handshake semantics:
//   Requester i raises req[i] (level) with its byte on req_data[i*DWL +: DWL]
//   and keeps it there until the arbiter has sampled it; the byte is captured
//   on the grant edge, and ack[i] pulses for one cycle once the byte has
//   fully left the serializer. Towards UART_Tx, tx_we is held high (with
//   tx_data stable) until tx_busy is seen high; the transfer is complete when
//   tx_busy falls again.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DWL   = 8
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]     req;
  logic [N_REQ*DWL-1:0] req_data;
  logic [N_REQ-1:0]     ack;
  logic [IW-1:0]        grant_id;
  logic                 arb_busy;
  logic                 tx_en;
  logic                 tx_we;
  logic [DWL-1:0]       tx_data;
  logic                 tx_busy;
  logic [1:0]           dbg_state;
`ifdef UART_ARB_TIMEOUT_EN
  logic                 err;
`endif

`ifdef UART_ARB_TIMEOUT_EN
  modport master (
    input  req, req_data, tx_busy,
    output ack, grant_id, arb_busy, tx_en, tx_we, tx_data, dbg_state, err
  );
  modport slave (
    output req, req_data, tx_busy,
    input  ack, grant_id, arb_busy, tx_en, tx_we, tx_data, dbg_state, err
  );
`else
  modport master (
    input  req, req_data, tx_busy,
    output ack, grant_id, arb_busy, tx_en, tx_we, tx_data, dbg_state
  );
  modport slave (
    output req, req_data, tx_busy,
    input  ack, grant_id, arb_busy, tx_en, tx_we, tx_data, dbg_state
  );
`endif

endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART_Tx serializer between N_REQ byte requesters with
//   round-robin arbitration. Generates the serializer's baud tick (tx_en),
//   loads the winning byte (tx_we/tx_data), waits for the serializer to go
//   busy and then idle again, and returns a one-cycle ack to the requester.
//
//   Parameters : N_REQ   number of requesters (2..16)
//                DWL     data word length (matches UART_Tx)
//                CLK_DIV CLK cycles per baud tick (>= 2)
//   Ports      : CLK  clock, rising edge
//                RST  synchronous, active-high reset
//                bus  uart_tx_arbiter_if.master (req/req_data/ack/grant_id/
//                     arb_busy/tx_en/tx_we/tx_data/tx_busy/dbg_state[/err])
//
//   Optional feature macro: UART_ARB_TIMEOUT_EN
//     When defined, a watchdog forces the ACK state after
//     16*CLK_DIV*(DWL+2) cycles in LOAD or WAIT_DONE and pulses bus.err
//     together with the ack. When undefined, LOAD and WAIT_DONE wait on
//     tx_busy indefinitely and bus.err does not exist.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DWL     = 8,
  parameter int CLK_DIV = 868
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_arbiter_if.master bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(CLK_DIV);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] PTR_RST   = IW'(N_REQ - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_ACK       = 2'd3;

  // ---------------------------------------------------------------------------
  // Baud tick: free-running, independent of the FSM.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;

  always_comb begin
    baud_cnt_d = (baud_cnt_q == BAUD_LAST) ? '0 : baud_cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) baud_cnt_q <= '0;
    else     baud_cnt_q <= baud_cnt_d;
  end

  assign bus.tx_en = (baud_cnt_q == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // Requester byte unpacking
  // ---------------------------------------------------------------------------
  logic [DWL-1:0] req_bytes [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*DWL +: DWL];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin winner: first set req bit searching ptr+1, ptr+2, ... mod N_REQ.
  // The last previously served requester is checked last, which gives every
  // other active requester one turn before it is served again.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] winner;
  logic          found;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(ptr_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic [DWL-1:0] tx_data_q, tx_data_d;
  logic           arb_busy_q, arb_busy_d;
  logic           timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_LIMIT = 16 * CLK_DIV * (DWL + 2);
  // At least 16 bits; widened when the limit would not fit in 16 bits.
  localparam int WW = ($clog2(TO_LIMIT + 1) > 16) ? $clog2(TO_LIMIT + 1) : 16;
  localparam logic [WW-1:0] WD_LAST = WW'(TO_LIMIT - 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  assign timeout_hit = ((state_q == S_LOAD) || (state_q == S_WAIT_DONE)) &&
                       (wd_q == WD_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    ptr_d      = ptr_q;
    arb_busy_d = arb_busy_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          // Grant and byte are captured here; later req/req_data changes do
          // not touch the byte in flight.
          grant_id_d = winner;
          tx_data_d  = req_bytes[winner];
          ptr_d      = winner;
          arb_busy_d = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = S_ACK;
      end
      S_ACK: begin
        arb_busy_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeout_hit) state_d = S_ACK;
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Watchdog restarts on every state entry and only runs in LOAD/WAIT_DONE.
  always_comb begin
    wd_d  = '0;
    err_d = timeout_hit;
    if ((state_d == state_q) &&
        ((state_q == S_LOAD) || (state_q == S_WAIT_DONE))) begin
      wd_d = wd_q + WW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  // err_q is only set on the edge into ACK, so it lines up with the ack pulse.
  assign bus.err = err_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      ptr_q      <= PTR_RST;
      arb_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      ptr_q      <= ptr_d;
      arb_busy_q <= arb_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.ack = '0;
    if (state_q == S_ACK) bus.ack[grant_id_q] = 1'b1;
  end

  assign bus.tx_we     = (state_q == S_LOAD);
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.arb_busy  = arb_busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with a small behavioural UART_Tx peer
//   that captures the serialized frame. A short CLK_DIV keeps runs brief.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DWL     = 8;
  localparam int CLK_DIV = 16;

  logic CLK;
  logic RST;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DWL(DWL)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .DWL(DWL), .CLK_DIV(CLK_DIV)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Behavioural UART_Tx: loads on tx_we when idle, shifts one bit per tx_en,
  // drops busy after start + DWL data + stop bits.
  // ---------------------------------------------------------------------------
  logic       m_busy;
  logic [9:0] m_sh;
  logic [3:0] m_cnt;
  logic [9:0] frame;
  logic       block_busy;

  always @(posedge CLK) begin
    if (RST) begin
      m_busy <= 1'b0;
      m_sh   <= '0;
      m_cnt  <= '0;
      frame  <= '0;
    end else if (!m_busy) begin
      if (bus.tx_we && !block_busy) begin
        m_busy <= 1'b1;
        m_sh   <= {1'b1, bus.tx_data, 1'b0};
        m_cnt  <= '0;
        frame  <= '0;
      end
    end else if (bus.tx_en) begin
      frame <= {m_sh[0], frame[9:1]};
      m_sh  <= m_sh >> 1;
      m_cnt <= m_cnt + 4'd1;
      if (m_cnt == 4'd9) m_busy <= 1'b0;
    end
  end

  assign bus.tx_busy = m_busy;

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    block_busy   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    bus.req_data[i*DWL +: DWL] = v;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (bus.tx_we !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.tx_we !== 1'b1) chk({name, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ack(input string name, input int bound);
    int n;
    n = 0;
    while (bus.ack === '0 && n < bound) begin
      tick();
      n++;
    end
    if (bus.ack === '0) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_wait_done(input string name);
    int n;
    n = 0;
    while (!(bus.tx_busy === 1'b1 && bus.tx_we === 1'b0) && n < 50) begin
      tick();
      n++;
    end
    if (!(bus.tx_busy === 1'b1 && bus.tx_we === 1'b0))
      chk({name, "_wait_done_timeout"}, 32'd0, 32'd1);
  endtask

  // Checks the cycle after an ack: pulse gone, arbiter released.
  task automatic chk_after_ack(input string name);
    tick();
    chk({name, "_ack_clear"}, 32'(bus.ack), 32'd0);
    chk({name, "_busy_clear"}, 32'(bus.arb_busy), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the held-request round-robin sequence
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] req;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
    logic [3:0] exp_ack;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int first_en, second_en, en_count, we_seen, ack_seen, busy_seen;

    vecs[0] = '{req: 4'b1111, exp_grant: 2'd0, exp_data: 8'h10, exp_ack: 4'b0001};
    vecs[1] = '{req: 4'b1111, exp_grant: 2'd1, exp_data: 8'h11, exp_ack: 4'b0010};
    vecs[2] = '{req: 4'b1111, exp_grant: 2'd2, exp_data: 8'h12, exp_ack: 4'b0100};
    vecs[3] = '{req: 4'b1111, exp_grant: 2'd3, exp_data: 8'h13, exp_ack: 4'b1000};
    vecs[4] = '{req: 4'b1111, exp_grant: 2'd0, exp_data: 8'h10, exp_ack: 4'b0001};

    // ---- 1) reset values and idle baud tick --------------------------------
    do_reset();
    chk("rst_ack",      32'(bus.ack),      32'd0);
    chk("rst_tx_we",    32'(bus.tx_we),    32'd0);
    chk("rst_tx_en",    32'(bus.tx_en),    32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("rst_err",      32'(bus.err),      32'd0);
`endif
    first_en = -1; second_en = -1; en_count = 0;
    we_seen = 0; ack_seen = 0; busy_seen = 0;
    for (int k = 0; k < 2*CLK_DIV; k++) begin
      if (bus.tx_en === 1'b1) begin
        if (en_count == 0) first_en = k;
        else if (en_count == 1) second_en = k;
        en_count++;
      end
      if (bus.tx_we !== 1'b0)    we_seen++;
      if (bus.ack !== '0)        ack_seen++;
      if (bus.arb_busy !== 1'b0) busy_seen++;
      tick();
    end
    chk("idle_en_count",  32'(en_count),  32'd2);
    chk("idle_first_en",  32'(first_en),  32'(CLK_DIV - 1));
    chk("idle_second_en", 32'(second_en), 32'(2*CLK_DIV - 1));
    chk("idle_tx_we",     32'(we_seen),   32'd0);
    chk("idle_ack",       32'(ack_seen),  32'd0);
    chk("idle_arb_busy",  32'(busy_seen), 32'd0);

    // ---- 2) single request, latency and serialized frame -------------------
    do_reset();
    set_byte(0, 8'hA5);
    bus.req = 4'b0001;
    chk("t2_we_first_cycle", 32'(bus.tx_we), 32'd0);
    tick();
    chk("t2_we_second_cycle", 32'(bus.tx_we),    32'd1);
    chk("t2_tx_data",         32'(bus.tx_data),  32'hA5);
    chk("t2_grant",           32'(bus.grant_id), 32'd0);
    chk("t2_arb_busy",        32'(bus.arb_busy), 32'd1);
    bus.req = 4'b0000;
    wait_ack("t2", 400);
    chk("t2_ack",   32'(bus.ack), 32'b0001);
    chk("t2_frame", 32'(frame),   32'b1_10100101_0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("t2_err", 32'(bus.err), 32'd0);
`endif
    chk_after_ack("t2");

    // ---- 3) all requesters held: round-robin order (table-driven) ----------
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_byte(i, 8'(8'h10 + i));
    for (int v = 0; v < 5; v++) begin
      bus.req = vecs[v].req;
      wait_grant($sformatf("t3_v%0d", v));
      chk($sformatf("t3_v%0d_grant", v),   32'(bus.grant_id), 32'(vecs[v].exp_grant));
      chk($sformatf("t3_v%0d_tx_data", v), 32'(bus.tx_data),  32'(vecs[v].exp_data));
      wait_ack($sformatf("t3_v%0d", v), 400);
      chk($sformatf("t3_v%0d_ack", v),   32'(bus.ack), 32'(vecs[v].exp_ack));
      chk($sformatf("t3_v%0d_frame", v), 32'(frame),   32'({1'b1, vecs[v].exp_data, 1'b0}));
      chk_after_ack($sformatf("t3_v%0d", v));
    end
    bus.req = 4'b0000;

    // ---- 4) data latched at grant; fairness after re-queue -----------------
    do_reset();
    set_byte(0, 8'h33);
    set_byte(2, 8'h44);
    bus.req = 4'b0101;
    wait_grant("t4a");
    chk("t4a_grant", 32'(bus.grant_id), 32'd0);
    wait_wait_done("t4a");
    set_byte(0, 8'hFF);
    wait_ack("t4a", 400);
    chk("t4a_ack",   32'(bus.ack), 32'b0001);
    chk("t4a_frame", 32'(frame),   32'b1_00110011_0);
    wait_grant("t4b");
    chk("t4b_grant",   32'(bus.grant_id), 32'd2);
    chk("t4b_tx_data", 32'(bus.tx_data),  32'h44);
    bus.req = 4'b0000;
    wait_ack("t4b", 400);
    chk("t4b_ack", 32'(bus.ack), 32'b0100);
    chk_after_ack("t4b");

    // ---- 5) reset during WAIT_DONE ------------------------------------------
    do_reset();
    set_byte(1, 8'h55);
    bus.req = 4'b0010;
    wait_grant("t5a");
    chk("t5a_grant", 32'(bus.grant_id), 32'd1);
    wait_wait_done("t5a");
    repeat (3) tick();
    RST = 1'b1;
    tick();
    chk("t5_rst_ack",      32'(bus.ack),      32'd0);
    chk("t5_rst_tx_we",    32'(bus.tx_we),    32'd0);
    chk("t5_rst_tx_en",    32'(bus.tx_en),    32'd0);
    chk("t5_rst_tx_data",  32'(bus.tx_data),  32'd0);
    chk("t5_rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("t5_rst_arb_busy", 32'(bus.arb_busy), 32'd0);
    RST = 1'b0;
    set_byte(3, 8'h77);
    bus.req = 4'b1000;
    tick();
    chk("t5b_we",      32'(bus.tx_we),    32'd1);
    chk("t5b_grant",   32'(bus.grant_id), 32'd3);
    chk("t5b_tx_data", 32'(bus.tx_data),  32'h77);
    bus.req = 4'b0000;
    wait_ack("t5b", 400);
    chk("t5b_ack",   32'(bus.ack), 32'b1000);
    chk("t5b_frame", 32'(frame),   32'b1_01110111_0);
    chk_after_ack("t5b");

`ifdef UART_ARB_TIMEOUT_EN
    // ---- 6) watchdog with the serializer never going busy ------------------
    do_reset();
    block_busy = 1'b1;
    set_byte(1, 8'h66);
    bus.req = 4'b0010;
    wait_grant("t6");
    bus.req = 4'b0000;
    wait_ack("t6", 16*CLK_DIV*(DWL+2) + 100);
    chk("t6_ack", 32'(bus.ack), 32'b0010);
    chk("t6_err", 32'(bus.err), 32'd1);
    tick();
    chk("t6_err_clear", 32'(bus.err), 32'd0);
    block_busy = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
